// File: rtl/parity_serializer.sv
// ---------------------------------------------------------------------------
// parity_serializer
//
// Takes a 9-bit word together with the two outputs of an external 9-bit
// parity generator and sends it out as a 12-bit asynchronous-style frame:
//   start bit (0), data bits 0..8 LSB first, one parity bit, stop bit (1).
// Each bit is held on the line for BIT_CYCLES clock cycles.
//
// The parity bit is not recomputed here. It is taken from the generator:
// odd_in when PARITY_SEL = 0 (even-parity frame), or even_in when
// PARITY_SEL = 1 (odd-parity frame). A healthy generator always presents
// even_in != odd_in. When both inputs are equal at capture, the capture is
// counted as faulty, but the frame is still sent.
//
// Parameters
//   PARITY_SEL  0 = send odd_in as the parity bit, 1 = send even_in
//   BIT_CYCLES  clock cycles per serial bit, 1..255
//
// Ports
//   clk        in   rising-edge clock
//   clr        in   synchronous active-high reset, has priority over start
//   start      in   frame request, sampled only while ready = 1
//   data_in    in   9-bit word to transmit
//   even_in    in   parity generator "even number of ones" output
//   odd_in     in   parity generator "odd number of ones" output
//   ready      out  idle and able to accept start
//   tx_out     out  registered serial line, idles high
//   done       out  one-cycle pulse in the idle cycle that follows a frame
//   fault      out  sticky: some capture had even_in == odd_in
//   fault_cnt  out  number of faulty captures, saturates at 15
// ---------------------------------------------------------------------------
module parity_serializer #(
  parameter int PARITY_SEL = 0,
  parameter int BIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic [8:0] data_in,
  input  logic       even_in,
  input  logic       odd_in,
  output logic       ready,
  output logic       tx_out,
  output logic       done,
  output logic       fault,
  output logic [3:0] fault_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  // Value of the bit-cycle counter in the last cycle of every serial bit.
  localparam logic [7:0] LastBitCycle = 8'(BIT_CYCLES - 1);
  // The bit index counts data bits 0..8. The parity bit follows index 8.
  localparam logic [3:0] LastDataIdx  = 4'd8;
  localparam logic [3:0] FaultCntMax  = 4'hF;

  state_e     state_q,    state_d;
  logic [7:0] bitCnt_q,   bitCnt_d;
  logic [3:0] bitIdx_q,   bitIdx_d;
  logic [8:0] shift_q,    shift_d;
  logic       parity_q,   parity_d;
  logic       tx_q,       tx_d;
  logic       done_q,     done_d;
  logic       fault_q,    fault_d;
  logic [3:0] faultCnt_q, faultCnt_d;

  logic bitEnd;
  logic selParity;
  logic parityBad;

  // Combinational helpers used by the next-state logic. bitEnd marks the
  // final cycle of the serial bit now on the line. selParity is the
  // generator output this instance sends as its parity bit. parityBad is
  // the consistency check made at capture.
  assign bitEnd    = (bitCnt_q == LastBitCycle);
  assign selParity = (PARITY_SEL != 0) ? even_in : odd_in;
  assign parityBad = (even_in == odd_in);

  // Next-state and next-output logic.
  //
  // tx_out comes straight from a flop. Each branch therefore computes the
  // line value for the *next* cycle. This is why the accepting edge already
  // loads the start bit (0), and why every bit boundary loads the following
  // bit. The data word is held in a shift register. The next data bit to
  // send is always shift_q[1], and shift_q[0] is the bit now on the line.
  //
  // The bit-cycle counter runs in every non-idle state and wraps at each
  // bit boundary. In IDLE, the counter and the bit index are held at zero.
  // As a result, every frame starts its START bit with a fresh count.
  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    bitIdx_d   = bitIdx_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    fault_d    = fault_q;
    faultCnt_d = faultCnt_q;

    if (state_q != IDLE) begin
      bitCnt_d = bitEnd ? 8'd0 : bitCnt_q + 8'd1;
    end

    unique case (state_q)
      IDLE: begin
        tx_d     = 1'b1;
        bitCnt_d = 8'd0;
        bitIdx_d = 4'd0;
        if (start) begin
          state_d  = START;
          shift_d  = data_in;
          parity_d = selParity;
          tx_d     = 1'b0;
          // A faulty capture still produces a frame. Only the flags record it.
          if (parityBad) begin
            fault_d = 1'b1;
            if (faultCnt_q != FaultCntMax) begin
              faultCnt_d = faultCnt_q + 4'd1;
            end
          end
        end
      end

      START: begin
        if (bitEnd) begin
          state_d  = DATA;
          bitIdx_d = 4'd0;
          tx_d     = shift_q[0];
        end
      end

      DATA: begin
        if (bitEnd) begin
          if (bitIdx_q == LastDataIdx) begin
            state_d = PARITY;
            tx_d    = parity_q;
          end else begin
            bitIdx_d = bitIdx_q + 4'd1;
            shift_d  = {1'b0, shift_q[8:1]};
            tx_d     = shift_q[1];
          end
        end
      end

      PARITY: begin
        if (bitEnd) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end

      STOP: begin
        // The idle cycle entered here is also the done cycle. A start seen
        // in that cycle is accepted, so frames can follow back-to-back.
        if (bitEnd) begin
          state_d = IDLE;
          tx_d    = 1'b1;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State and output registers. clr is checked first. This aborts any frame
  // in flight, returns the line to idle-high without a done pulse, and
  // blocks acceptance of a start seen on the same edge.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= IDLE;
      bitCnt_q   <= 8'd0;
      bitIdx_q   <= 4'd0;
      shift_q    <= 9'd0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      faultCnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      bitIdx_q   <= bitIdx_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
      fault_q    <= fault_d;
      faultCnt_q <= faultCnt_d;
    end
  end

  // ready depends only on the state register, so it has no path from any
  // input. The other outputs are flops driven directly.
  assign ready     = (state_q == IDLE);
  assign tx_out    = tx_q;
  assign done      = done_q;
  assign fault     = fault_q;
  assign fault_cnt = faultCnt_q;

endmodule
